legv8_alu_sequencer: RTL

Registered issue/response front end for the combinational LEGv8 ALU: it accepts one decoded ALU operation per valid/ready handshake, encodes it into the ALU's function-select (FS) and carry-in (C0) controls, and presents latched operands. It captures the ALU result and status, and maintains the architectural NZCV flags register. It is the driving end of the ALU's FS/C0/operand interface and sits between the decode stage and writeback.

---
 rtl/legv8_alu_pkg.sv | 41 ++++
 rtl/legv8_alu_op_decode.sv | 41 ++++
 rtl/legv8_alu_sequencer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/legv8_alu_pkg.sv
// Shared constants for the LEGv8 ALU issue/response front end:
// op codes, ALU function selects, flag bit positions and FSM states.
package legv8_alu_pkg;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_ORR  = 4'd1;
    localparam logic [3:0] OP_EOR  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_LSL  = 4'd5;
    localparam logic [3:0] OP_LSR  = 4'd6;
    localparam logic [3:0] OP_NOR  = 4'd7;
    localparam logic [3:0] OP_NAND = 4'd8;
    localparam logic [3:0] OP_ANDS = 4'd9;
    localparam logic [3:0] OP_ADDS = 4'd10;
    localparam logic [3:0] OP_SUBS = 4'd11;
    localparam logic [3:0] OP_NEG  = 4'd12;
    localparam logic [3:0] OP_MOV  = 4'd13;

    localparam logic [4:0] FS_AND  = 5'b00000;
    localparam logic [4:0] FS_ORR  = 5'b00100;
    localparam logic [4:0] FS_EOR  = 5'b01100;
    localparam logic [4:0] FS_ADD  = 5'b01000;
    localparam logic [4:0] FS_SUB  = 5'b01001;
    localparam logic [4:0] FS_LSL  = 5'b10000;
    localparam logic [4:0] FS_LSR  = 5'b10100;
    localparam logic [4:0] FS_NOR  = 5'b00011;
    localparam logic [4:0] FS_NAND = 5'b00111;

    localparam int unsigned FLAG_V = 3;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_Z = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/legv8_alu_op_decode.sv
// Combinational decode of an ALU op code into ALU controls and flag policy.
module legv8_alu_op_decode
    import legv8_alu_pkg::*;
(
    input  logic [3:0] op,
    output logic [4:0] fs,
    output logic       c0,
    output logic       force_a_zero,
    output logic       set_flags,
    output logic       logical_flags,
    output logic       illegal
);

    // Map each op code to its function select, carry-in and side effects.
    always_comb begin
        fs            = FS_AND;
        c0            = 1'b0;
        force_a_zero  = 1'b0;
        set_flags     = 1'b0;
        logical_flags = 1'b0;
        illegal       = 1'b0;
        case (op)
            OP_AND:  fs = FS_AND;
            OP_ORR:  fs = FS_ORR;
            OP_EOR:  fs = FS_EOR;
            OP_ADD:  fs = FS_ADD;
            OP_SUB:  begin fs = FS_SUB; c0 = 1'b1; end
            OP_LSL:  fs = FS_LSL;
            OP_LSR:  fs = FS_LSR;
            OP_NOR:  fs = FS_NOR;
            OP_NAND: fs = FS_NAND;
            OP_ANDS: begin fs = FS_AND; set_flags = 1'b1; logical_flags = 1'b1; end
            OP_ADDS: begin fs = FS_ADD; set_flags = 1'b1; end
            OP_SUBS: begin fs = FS_SUB; c0 = 1'b1; set_flags = 1'b1; end
            OP_NEG:  begin fs = FS_SUB; c0 = 1'b1; force_a_zero = 1'b1; end
            OP_MOV:  begin fs = FS_ORR; force_a_zero = 1'b1; end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/legv8_alu_sequencer.sv
// Registered valid/ready front end for the combinational LEGv8 ALU.
// Latches one op, drives the ALU for one cycle, captures result and NZCV.
module legv8_alu_sequencer
    import legv8_alu_pkg::*;
#(
    parameter int W = 64
)
(
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   in_op,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [4:0]   alu_fs,
    output logic         alu_c0,
    input  logic [W-1:0] alu_f,
    input  logic [3:0]   alu_status,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_f,
    output logic         out_err,
    output logic [3:0]   flags
);

    state_t     state;
    state_t     state_next;
    logic       accept;

    logic [4:0] dec_fs;
    logic       dec_c0;
    logic       dec_force_a_zero;
    logic       dec_set_flags;
    logic       dec_logical_flags;
    logic       dec_illegal;

    logic       set_flags_q;
    logic       logical_flags_q;
    logic       illegal_q;

    legv8_alu_op_decode u_decode (
        .op            (in_op),
        .fs            (dec_fs),
        .c0            (dec_c0),
        .force_a_zero  (dec_force_a_zero),
        .set_flags     (dec_set_flags),
        .logical_flags (dec_logical_flags),
        .illegal       (dec_illegal)
    );

    assign accept = in_valid & in_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_next = ST_RESP;
            end
            ST_RESP: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    state_next = in_valid ? ST_EXEC : ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Decode is done at accept time so the ALU sees only registered controls.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_a           <= '0;
            alu_b           <= '0;
            alu_fs          <= '0;
            alu_c0          <= 1'b0;
            set_flags_q     <= 1'b0;
            logical_flags_q <= 1'b0;
            illegal_q       <= 1'b0;
        end else if (accept) begin
            alu_a           <= dec_force_a_zero ? '0 : in_a;
            alu_b           <= in_b;
            alu_fs          <= dec_fs;
            alu_c0          <= dec_c0;
            set_flags_q     <= dec_set_flags;
            logical_flags_q <= dec_logical_flags;
            illegal_q       <= dec_illegal;
        end
    end

    // Capture the ALU result and update NZCV at the end of EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_f   <= '0;
            out_err <= 1'b0;
            flags   <= '0;
        end else if (state == ST_EXEC) begin
            out_f   <= illegal_q ? '0 : alu_f;
            out_err <= illegal_q;
            if (set_flags_q && !illegal_q) begin
                flags[FLAG_N] <= alu_status[FLAG_N];
                flags[FLAG_Z] <= alu_status[FLAG_Z];
                flags[FLAG_C] <= logical_flags_q ? 1'b0 : alu_status[FLAG_C];
                flags[FLAG_V] <= logical_flags_q ? 1'b0 : alu_status[FLAG_V];
            end
        end
    end

endmodule
